// File: rtl/rf_input_supervisor_if.sv
// Bundle of control, bitstream and status signals between the system side
// and the RF input supervisor.
`timescale 1ns/1ps
interface rf_input_supervisor_if #(
    parameter int unsigned WINDOW_LOG2 = 12
);
    logic                          enable;
    logic                          bit_in;
    logic                          overload_clear;
    logic                          frontend_sreset;
    logic                          ready;
    logic signed [WINDOW_LOG2+1:0] dc_offset;
    logic                          dc_valid;
    logic                          overload;
    logic                          fault;
    logic [2:0]                    state;

    modport master (
        output enable, bit_in, overload_clear,
        input  frontend_sreset, ready, dc_offset, dc_valid, overload, fault, state
    );

    modport slave (
        input  enable, bit_in, overload_clear,
        output frontend_sreset, ready, dc_offset, dc_valid, overload, fault, state
    );
endinterface

// File: rtl/rf_input_supervisor.sv
// Start-up sequencer, DC offset monitor and saturation watchdog for the 1-bit
// sigma-delta RF input. Restarts the front end on overload and latches FAULT
// after too many consecutive restarts.
`timescale 1ns/1ps
module rf_input_supervisor #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 4096,
    parameter int unsigned WINDOW_LOG2   = 12,
    parameter int unsigned RUN_LIMIT     = 64,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input logic                 clock,
    input logic                 clock_areset_n,
    rf_input_supervisor_if.slave bus
);
    localparam int unsigned PHASE_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned RUN_W     = $clog2(RUN_LIMIT + 1);
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRIES + 2);
    localparam int unsigned ACC_W     = WINDOW_LOG2 + 2;

    localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(HOLD_CYCLES - 1);
    localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
    localparam logic [RUN_W-1:0]   RUN_LIM_V   = RUN_W'(RUN_LIMIT);
    localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StHold    = 3'd1,
        StSettle  = 3'd2,
        StMeasure = 3'd3,
        StRun     = 3'd4,
        StFault   = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic [PHASE_W-1:0]        phase_q, phase_d;
    logic [WINDOW_LOG2-1:0]    win_q, win_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [RUN_W-1:0]          run_q, run_d;
    logic                      prev_q, prev_d;
    logic [RETRY_W-1:0]        retry_q, retry_d;
    logic signed [ACC_W-1:0]   offset_q, offset_d;
    logic                      valid_q, valid_d;
    logic                      overload_q, overload_d;
    logic                      sreset_q, ready_q, fault_q;

    logic signed [ACC_W-1:0]   acc_next;
    logic [RUN_W-1:0]          run_next;
    logic [RETRY_W-1:0]        retry_inc;

    // Per-sample helpers: accumulator step, run length (0 means no previous sample)
    assign acc_next  = acc_q + (bus.bit_in ? ACC_W'(1) : {ACC_W{1'b1}});
    assign run_next  = (run_q == '0 || bus.bit_in != prev_q) ? RUN_W'(1) : run_q + RUN_W'(1);
    assign retry_inc = retry_q + RETRY_W'(1);

    // Next-state, counters and measurement results
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        win_d      = win_q;
        acc_d      = acc_q;
        run_d      = run_q;
        prev_d     = prev_q;
        retry_d    = retry_q;
        offset_d   = offset_q;
        valid_d    = 1'b0;
        overload_d = overload_q & ~bus.overload_clear;

        if (!bus.enable) begin
            state_d = StIdle;
            phase_d = '0;
            win_d   = '0;
            acc_d   = '0;
            run_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StHold;
                    phase_d = '0;
                end
                StHold: begin
                    if (phase_q == HOLD_LAST) begin
                        state_d = StSettle;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
                StSettle: begin
                    if (phase_q == SETTLE_LAST) begin
                        state_d = StMeasure;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
                StMeasure, StRun: begin
                    prev_d = bus.bit_in;
                    run_d  = run_next;
                    win_d  = win_q + WINDOW_LOG2'(1);
                    acc_d  = acc_next;
                    // Overload takes precedence over a coincident window end
                    if (run_next == RUN_LIM_V) begin
                        overload_d = 1'b1;
                        retry_d    = retry_inc;
                        state_d    = (retry_inc <= MAX_RETRY_V) ? StHold : StFault;
                        win_d      = '0;
                        acc_d      = '0;
                        run_d      = '0;
                    end else if (win_q == '1) begin
                        offset_d = acc_next;
                        valid_d  = 1'b1;
                        acc_d    = '0;
                        state_d  = StRun;
                        if (state_q == StMeasure) begin
                            retry_d = '0;
                        end
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and registered outputs; decoded outputs follow the next state
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            win_q      <= '0;
            acc_q      <= '0;
            run_q      <= '0;
            prev_q     <= 1'b0;
            retry_q    <= '0;
            offset_q   <= '0;
            valid_q    <= 1'b0;
            overload_q <= 1'b0;
            sreset_q   <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            retry_q    <= retry_d;
            offset_q   <= offset_d;
            valid_q    <= valid_d;
            overload_q <= overload_d;
            sreset_q   <= (state_d == StIdle) || (state_d == StHold) || (state_d == StFault);
            ready_q    <= (state_d == StRun);
            fault_q    <= (state_d == StFault);
        end
    end

    assign bus.state           = state_q;
    assign bus.frontend_sreset = sreset_q;
    assign bus.ready           = ready_q;
    assign bus.dc_offset       = offset_q;
    assign bus.dc_valid        = valid_q;
    assign bus.overload        = overload_q;
    assign bus.fault           = fault_q;
endmodule

// File: tb/tb_rf_input_supervisor.sv
// Directed bench for rf_input_supervisor: table of window patterns with
// hand-computed offsets plus sequences for overload, retry, FAULT and resets.
`timescale 1ns/1ps
module tb_rf_input_supervisor;
    localparam int H  = 16;
    localparam int S  = 64;
    localparam int WL = 6;
    localparam int N  = 64;
    localparam int RL = 64;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    rf_input_supervisor_if #(.WINDOW_LOG2(WL)) bus ();

    rf_input_supervisor #(
        .HOLD_CYCLES  (H),
        .SETTLE_CYCLES(S),
        .WINDOW_LOG2  (WL),
        .RUN_LIMIT    (RL),
        .MAX_RETRIES  (3)
    ) dut (
        .clock         (clock),
        .clock_areset_n(rst_n),
        .bus           (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] pat;
        int         exp;
    } vec_t;

    vec_t vecs[6];
    int   n_vec = 0;
    int   n_err = 0;
    int   pulses;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One window of a repeating 4-bit pattern, first bit = pat[3]; counts early dc_valid
    task automatic feed_window(input logic [3:0] pat, output int early);
        early = 0;
        for (int i = 0; i < N; i++) begin
            bus.bit_in = pat[3 - (i % 4)];
            step();
            if (i < N - 1 && bus.dc_valid) early++;
        end
    endtask

    // From HOLD entry with bit_in held at 1: restart sequence then overload from MEASURE entry
    task automatic const_cycle(input int exp_state, input string name);
        bus.bit_in = 1'b1;
        repeat (H + S + RL - 1) step();
        check({name, "_pre_state"}, bus.state, 3);
        step();
        check({name, "_state"}, bus.state, exp_state);
        check({name, "_overload"}, bus.overload, 1);
        check({name, "_sreset"}, bus.frontend_sreset, 1);
        check({name, "_no_valid"}, bus.dc_valid, 0);
    endtask

    initial begin
        vecs[0] = '{pat: 4'b1110, exp:  32};
        vecs[1] = '{pat: 4'b0001, exp: -32};
        vecs[2] = '{pat: 4'b1100, exp:   0};
        vecs[3] = '{pat: 4'b0100, exp: -32};
        vecs[4] = '{pat: 4'b1011, exp:  32};
        vecs[5] = '{pat: 4'b1010, exp:   0};

        bus.enable         = 1'b0;
        bus.bit_in         = 1'b0;
        bus.overload_clear = 1'b0;
        repeat (3) step();
        check("rst_state", bus.state, 0);
        check("rst_sreset", bus.frontend_sreset, 1);
        check("rst_ready", bus.ready, 0);
        check("rst_offset", bus.dc_offset, 0);
        check("rst_valid", bus.dc_valid, 0);
        check("rst_overload", bus.overload, 0);
        check("rst_fault", bus.fault, 0);
        #2 rst_n = 1'b1;
        repeat (10) step();
        check("idle_state", bus.state, 0);

        // Start-up timing
        bus.enable = 1'b1;
        step();
        check("hold_entry", bus.state, 1);
        repeat (H - 1) step();
        check("hold_last", bus.state, 1);
        check("hold_sreset", bus.frontend_sreset, 1);
        step();
        check("settle_entry", bus.state, 2);
        check("settle_sreset", bus.frontend_sreset, 0);
        repeat (S - 1) step();
        check("settle_last", bus.state, 2);
        step();
        check("measure_entry", bus.state, 3);
        check("measure_ready", bus.ready, 0);

        // First window: alternating bits
        feed_window(4'b0101, pulses);
        check("first_early_valid", pulses, 0);
        check("first_valid", bus.dc_valid, 1);
        check("first_ready", bus.ready, 1);
        check("first_state", bus.state, 4);
        check("first_offset", bus.dc_offset, 0);

        // Back-to-back RUN windows from the table
        for (int v = 0; v < 6; v++) begin
            feed_window(vecs[v].pat, pulses);
            check($sformatf("vec%0d_early", v), pulses, 0);
            check($sformatf("vec%0d_valid", v), bus.dc_valid, 1);
            check($sformatf("vec%0d_offset", v), bus.dc_offset, vecs[v].exp);
        end

        // Overload in RUN spanning a window end; clear coincides with the set
        for (int i = 0; i < 10; i++) begin
            bus.bit_in = (i % 2 == 0);
            step();
        end
        for (int i = 0; i < RL; i++) begin
            bus.bit_in         = 1'b1;
            bus.overload_clear = (i == RL - 1);
            step();
            if (i == 53) begin
                check("span_valid", bus.dc_valid, 1);
                check("span_offset", bus.dc_offset, 54);
            end
        end
        bus.overload_clear = 1'b0;
        check("ovl_flag", bus.overload, 1);
        check("ovl_state", bus.state, 1);
        check("ovl_ready", bus.ready, 0);
        check("ovl_sreset", bus.frontend_sreset, 1);
        check("ovl_no_valid", bus.dc_valid, 0);
        check("ovl_offset_kept", bus.dc_offset, 54);

        // Clear the flag during HOLD, then the remaining restart
        bus.overload_clear = 1'b1;
        step();
        bus.overload_clear = 1'b0;
        check("ovl_cleared", bus.overload, 0);
        repeat (H + S + RL - 2) step();
        check("coinc_pre_state", bus.state, 3);
        step();
        check("coinc_state", bus.state, 1);
        check("coinc_overload", bus.overload, 1);
        check("coinc_no_valid", bus.dc_valid, 0);
        check("coinc_offset_kept", bus.dc_offset, 54);

        // Third and fourth consecutive overloads
        const_cycle(1, "retry3");
        const_cycle(5, "retry4");
        check("fault_flag", bus.fault, 1);
        check("fault_ready", bus.ready, 0);
        repeat (5) step();
        check("fault_stays", bus.state, 5);
        bus.enable = 1'b0;
        step();
        check("fault_to_idle", bus.state, 0);
        check("idle_fault_low", bus.fault, 0);
        check("idle_overload_sticky", bus.overload, 1);

        // Three overloads, a clean MEASURE, then three more must not fault
        bus.enable = 1'b1;
        step();
        check("re_hold", bus.state, 1);
        const_cycle(1, "r1");
        const_cycle(1, "r2");
        const_cycle(1, "r3");
        repeat (H + S) step();
        check("ok_measure", bus.state, 3);
        feed_window(4'b1010, pulses);
        check("ok_valid", bus.dc_valid, 1);
        check("ok_offset", bus.dc_offset, 0);
        check("ok_state", bus.state, 4);
        bus.bit_in = 1'b1;
        repeat (RL) step();
        check("after_ok_1", bus.state, 1);
        check("after_ok_offset", bus.dc_offset, 0);
        const_cycle(1, "after_ok_2");
        const_cycle(1, "after_ok_3");
        check("after_ok_no_fault", bus.fault, 0);

        // Drop enable mid-SETTLE; timing restarts from HOLD
        repeat (H + 10) step();
        check("mid_settle", bus.state, 2);
        bus.enable = 1'b0;
        step();
        check("drop_idle", bus.state, 0);
        check("drop_sreset", bus.frontend_sreset, 1);
        bus.enable = 1'b1;
        step();
        check("re2_hold", bus.state, 1);
        repeat (H - 1) step();
        check("re2_hold_last", bus.state, 1);
        step();
        check("re2_settle", bus.state, 2);
        repeat (S - 1) step();
        check("re2_settle_last", bus.state, 2);
        step();
        check("re2_measure", bus.state, 3);
        feed_window(4'b1110, pulses);
        check("re2_offset", bus.dc_offset, 32);
        check("re2_ready", bus.ready, 1);

        // Asynchronous reset mid-RUN
        for (int i = 0; i < 20; i++) begin
            bus.bit_in = (i % 2 == 0);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("areset_state", bus.state, 0);
        check("areset_ready", bus.ready, 0);
        check("areset_sreset", bus.frontend_sreset, 1);
        check("areset_offset", bus.dc_offset, 0);
        check("areset_overload", bus.overload, 0);
        check("areset_valid", bus.dc_valid, 0);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_hold", bus.state, 1);
        repeat (H - 1) step();
        check("post_rst_hold_last", bus.state, 1);
        step();
        check("post_rst_settle", bus.state, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rf_input_supervisor.md
# rf_input_supervisor

Sequencer and health monitor for the 1-bit LVDS sigma-delta RF input. It drives the front end's synchronous reset through a hold/settle start-up sequence and measures the bitstream DC offset over fixed windows. It also detects loop saturation (over-long runs of identical bits) and automatically restarts the front end, giving up into a FAULT state after repeated failures. It sits between the system control registers and the RF input stage, and gates downstream DSP through `ready`.

## Interface
- `HOLD_CYCLES`, 16: cycles `frontend_sreset` is held high on each (re)start.
- `SETTLE_CYCLES`, 4096: cycles after reset release before measurement begins.
- `WINDOW_LOG2`, 12: measurement window N = 2^WINDOW_LOG2 samples.
- `RUN_LIMIT`, 64: consecutive identical bits that declare overload (≥2).
- `MAX_RETRIES`, 3: consecutive overload restarts tolerated before FAULT.
- `clock` in 1: sample clock, same clock as the RF input stage.
- `clock_areset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; high runs the sequence, low forces IDLE.
- `bit_in` in 1: resynchronised comparator bit from the front end (1 = positive).
- `overload_clear` in 1: single-cycle pulse clearing the sticky `overload` flag.
- `frontend_sreset` out 1: synchronous reset to the RF input stage.
- `ready` out 1: high only in RUN.
- `dc_offset` out signed WINDOW_LOG2+2: (#ones − #zeros) over the last completed window; range −N..+N.
- `dc_valid` out 1: one-cycle pulse when `dc_offset` updates.
- `overload` out 1: sticky saturation flag.
- `fault` out 1: high in FAULT.
- `state` out 3: IDLE=0, HOLD=1, SETTLE=2, MEASURE=3, RUN=4, FAULT=5.

## Operation
- FSM, all transitions on `clock` rising edge:
  - IDLE: `frontend_sreset`=1. Go to HOLD when `enable`=1.
  - HOLD: `frontend_sreset`=1 for HOLD_CYCLES cycles, then go to SETTLE.
  - SETTLE: `frontend_sreset`=0. Count SETTLE_CYCLES cycles, then go to MEASURE. `bit_in` is ignored.
  - MEASURE: accumulate one window. At window end, pulse `dc_valid`, clear the retry counter, and go to RUN.
  - RUN: accumulate windows back-to-back, pulsing `dc_valid` at the end of each. `ready`=1.
  - FAULT: `frontend_sreset`=1 and `fault`=1. Stay until `enable`=0.
- `enable`=0 in any state: go to IDLE next edge. Window, run, settle and retry counters are cleared. `overload` and `dc_offset` keep their values.
- Accumulator: up/down counter, +1 for `bit_in`=1 and −1 for 0, one sample per cycle in MEASURE/RUN. On the N-th sample, `dc_offset` ← accumulator including that sample, and the accumulator restarts from 0 with no gap cycle. All-ones gives +N, all-zeros −N, alternating gives 0.
- Run monitor, active only in MEASURE/RUN:
  - The run counter restarts at 1 on entry and whenever `bit_in` differs from the previous sample.
  - When it reaches RUN_LIMIT: `overload` is set, the partial window is discarded (no `dc_valid`), and the retry counter increments.
  - Next state is HOLD if retries ≤ MAX_RETRIES, otherwise FAULT.
- `overload` clears on `overload_clear` only. If set and clear occur in the same cycle, set wins.
- A window end and an overload on the same sample: overload wins, with no `dc_valid` and no `dc_offset` update.

## Timing
- Reset values: `state`=IDLE, `frontend_sreset`=1, `ready`=0, `dc_offset`=0, `dc_valid`=0, `overload`=0, `fault`=0, all counters 0.
- All outputs are registered.
- `enable` rising at edge k: HOLD visible from k+1, `frontend_sreset` falls at k+1+HOLD_CYCLES, MEASURE at k+1+HOLD_CYCLES+SETTLE_CYCLES.
- The first `dc_valid` arrives N cycles after MEASURE entry, with `ready`=1 in the same cycle. Thereafter `dc_valid` repeats every N cycles.
- Overload: `overload`=1, `state`=HOLD/FAULT, `ready`=0 and `frontend_sreset`=1 are all visible in the cycle after the RUN_LIMIT-th identical sample is registered.
- An asynchronous reset mid-operation returns everything to reset values immediately. A full sequence restarts once reset is released with `enable`=1.

## Test plan
- Alternating `bit_in`, `enable` raised at cycle 10 with defaults: HOLD 16 cycles, SETTLE 4096, `dc_valid` at MEASURE entry+4096 with `dc_offset`=0, `ready`=1, pulses every 4096 cycles.
- Pattern 1,1,1,0 repeated (WINDOW_LOG2=4): `dc_offset`=+8 each window. Pattern 0,0,0,1: −8.
- Constant `bit_in`=1 in RUN (RUN_LIMIT=64): overload one cycle after the 64th sample, `state`=HOLD, no `dc_valid`, restart sequence runs. `overload_clear` coinciding with a new overload leaves the flag at 1.
- Constant `bit_in` persisting: four consecutive overloads (MAX_RETRIES=3) → FAULT with `frontend_sreset`=1. Dropping `enable` → IDLE. A later clean MEASURE completion clears the retry count (verify three overloads, then success, then three more do not fault).
- Window end coincident with the RUN_LIMIT-th sample (WINDOW_LOG2=6, RUN_LIMIT=64, constant input from MEASURE entry): overload taken, `dc_offset` unchanged.
- `enable` dropped mid-SETTLE and `clock_areset_n` pulsed mid-RUN: IDLE next edge / immediate reset values respectively. The re-enabled sequence restarts its timing from HOLD.
